// File: rtl/fu_gst_nrm_pkg.sv
// rtl/fu_gst_nrm_pkg.sv - shared gst normalizer constants and stage payload
package fu_gst_nrm_pkg;

  localparam int GST_FRAC_W  = 19;
  localparam int GST_SHAMT_W = 5;
  localparam int GST_EXP_W   = 8;

  localparam logic [GST_SHAMT_W-1:0] GST_CODE_ZERO = '0;
  localparam logic [GST_SHAMT_W-1:0] GST_CODE_MAX  = 5'd19;

  typedef struct packed {
    logic [1:GST_FRAC_W]  frac;
    logic [0:GST_EXP_W-1] exp;
    logic                 zero;
    logic                 inv;
  } gst_pay_t;

endpackage

// File: rtl/fu_gst_nrm_shf.sv
// rtl/fu_gst_nrm_shf.sv - combinational left shifter over a fixed set of weights
module fu_gst_nrm_shf
  import fu_gst_nrm_pkg::*;
#(
  parameter int              NW  = 3,
  parameter logic [NW*5-1:0] WTS = {5'd16, 5'd8, 5'd4}
) (
  input  logic [1:GST_FRAC_W] din,
  input  logic [0:NW-1]       sel,
  output logic [1:GST_FRAC_W] dout
);

  logic [1:GST_FRAC_W] d;

  // sel[0] pairs with the most significant weight field of WTS
  always_comb begin
    d = din;
    for (int i = 0; i < NW; i++) begin
      if (sel[i]) d = d << WTS[(NW-1-i)*5 +: 5];
    end
    dout = d;
  end

endmodule

// File: rtl/fu_gst_nrm.sv
// rtl/fu_gst_nrm.sv - two-stage gst fraction normalizer with exponent adjust
module fu_gst_nrm
  import fu_gst_nrm_pkg::*;
#(
  parameter int EXP_W = GST_EXP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vld,
  output logic                   i_rdy,
  input  logic [1:GST_FRAC_W]    i_frac,
  input  logic [0:GST_SHAMT_W-1] i_shamt,
  input  logic [0:EXP_W-1]       i_exp,
  input  logic                   i_flush,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [1:GST_FRAC_W]    o_frac,
  output logic [0:EXP_W]         o_exp,
  output logic                   o_zero,
  output logic                   o_inv,
  output logic                   o_unf,
  output logic                   o_mis
);

  logic                   s1_vld, s2_vld, s1_adv, s2_adv;
  logic [0:GST_SHAMT_W-1] in_sh, s1_sh;
  logic                   in_legal;
  logic [1:GST_FRAC_W]    crs_frac, fin_frac;
  logic [0:EXP_W]         exp_adj;
  gst_pay_t               s1_nxt, s1_pay;

  assign s2_adv = ~s2_vld | o_rdy;
  assign s1_adv = ~s1_vld | s2_adv;
  assign i_rdy  = s1_adv & ~i_flush;
  assign o_vld  = s2_vld;

  // k-1 is the shift distance; codes 0 and 20..31 are forced to zero downstream
  assign in_sh    = i_shamt - GST_SHAMT_W'(1);
  assign in_legal = (i_shamt != GST_CODE_ZERO) && (i_shamt <= GST_CODE_MAX);

  fu_gst_nrm_shf #(
    .NW (3),
    .WTS({5'd16, 5'd8, 5'd4})
  ) u_crs (
    .din (i_frac),
    .sel (in_sh[0:2]),
    .dout(crs_frac)
  );

  always_comb begin
    s1_nxt      = '0;
    s1_nxt.frac = crs_frac;
    s1_nxt.exp  = i_exp;
    s1_nxt.zero = ~in_legal;
    s1_nxt.inv  = i_shamt > GST_CODE_MAX;
  end

  fu_gst_nrm_shf #(
    .NW (2),
    .WTS({5'd2, 5'd1})
  ) u_fin (
    .din (s1_pay.frac),
    .sel (s1_sh[3:4]),
    .dout(fin_frac)
  );

  assign exp_adj = {1'b0, s1_pay.exp} - (EXP_W+1)'(s1_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_pay <= '0;
      s1_sh  <= '0;
      o_frac <= '0;
      o_exp  <= '0;
      o_zero <= 1'b0;
      o_inv  <= 1'b0;
      o_unf  <= 1'b0;
      o_mis  <= 1'b0;
    end else if (i_flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          o_frac <= s1_pay.zero ? '0 : fin_frac;
          o_exp  <= s1_pay.zero ? '0 : exp_adj;
          o_zero <= s1_pay.zero;
          o_inv  <= s1_pay.inv;
          o_unf  <= ~s1_pay.zero & exp_adj[0];
          o_mis  <= ~s1_pay.zero & ~fin_frac[1];
        end
      end
      if (s1_adv) begin
        s1_vld <= i_vld;
        if (i_vld) begin
          s1_pay <= s1_nxt;
          s1_sh  <= in_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_gst_nrm.sv
// tb/tb_fu_gst_nrm.sv - directed vector bench for fu_gst_nrm
module tb_fu_gst_nrm;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld, i_rdy, i_flush, o_vld, o_rdy;
  logic [1:19] i_frac, o_frac;
  logic [0:4]  i_shamt;
  logic [0:7]  i_exp;
  logic [0:8]  o_exp;
  logic        o_zero, o_inv, o_unf, o_mis;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fu_gst_nrm #(.EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_frac(i_frac), .i_shamt(i_shamt),
    .i_exp(i_exp), .i_flush(i_flush),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_frac(o_frac), .o_exp(o_exp),
    .o_zero(o_zero), .o_inv(o_inv), .o_unf(o_unf), .o_mis(o_mis)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [18:0] frac;
    logic [4:0]  k;
    logic [7:0]  e;
    logic [18:0] xf;
    logic [8:0]  xe;
    logic        z, inv, unf, mis;
  } vec_t;

  vec_t v[12];
  logic [7:0] seq_e[3];

  initial begin
    v[0]  = '{19'h00400, 5'd9,  8'd100, 19'h40000, 9'd92,  1'b0, 1'b0, 1'b0, 1'b0};
    v[1]  = '{19'h00000, 5'd0,  8'd77,  19'h00000, 9'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    v[2]  = '{19'h12345, 5'd23, 8'd50,  19'h00000, 9'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    v[3]  = '{19'h00001, 5'd19, 8'd5,   19'h40000, 9'h1F3, 1'b0, 1'b0, 1'b1, 1'b0};
    v[4]  = '{19'h04000, 5'd4,  8'd10,  19'h20000, 9'd7,   1'b0, 1'b0, 1'b0, 1'b1};
    v[5]  = '{19'h5A5A5, 5'd1,  8'd200, 19'h5A5A5, 9'd200, 1'b0, 1'b0, 1'b0, 1'b0};
    v[6]  = '{19'h3FFFF, 5'd2,  8'd0,   19'h7FFFE, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0};
    v[7]  = '{19'h7FFFF, 5'd31, 8'd255, 19'h00000, 9'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    v[8]  = '{19'h00001, 5'd20, 8'd3,   19'h00000, 9'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    v[9]  = '{19'h00004, 5'd17, 8'd255, 19'h40000, 9'd239, 1'b0, 1'b0, 1'b0, 1'b0};
    v[10] = '{19'h000DF, 5'd12, 8'd11,  19'h6F800, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0};
    v[11] = '{19'h00000, 5'd19, 8'd20,  19'h00000, 9'd2,   1'b0, 1'b0, 1'b0, 1'b1};
    seq_e = '{8'd10, 8'd20, 8'd30};

    rst = 1'b1; i_vld = 1'b0; i_flush = 1'b0; o_rdy = 1'b1;
    i_frac = '0; i_shamt = '0; i_exp = '0;
    #12;
    chk("rst.o_vld", 32'(o_vld), 32'd0);
    chk("rst.o_frac", 32'(o_frac), 32'd0);
    chk("rst.o_exp", 32'(o_exp), 32'd0);
    chk("rst.o_zero", 32'(o_zero), 32'd0);
    chk("rst.i_rdy", 32'(i_rdy), 32'd1);
    @(negedge clk); rst = 1'b0;

    // one beat at a time, two-edge latency
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      i_vld = 1'b1; i_frac = v[i].frac; i_shamt = v[i].k; i_exp = v[i].e;
      @(posedge clk); #1;
      i_vld = 1'b0;
      chk($sformatf("v%0d.lat1", i), 32'(o_vld), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d.o_vld", i), 32'(o_vld), 32'd1);
      chk($sformatf("v%0d.frac", i), 32'(o_frac), 32'(v[i].xf));
      chk($sformatf("v%0d.exp", i), 32'(o_exp), 32'(v[i].xe));
      chk($sformatf("v%0d.zero", i), 32'(o_zero), 32'(v[i].z));
      chk($sformatf("v%0d.inv", i), 32'(o_inv), 32'(v[i].inv));
      chk($sformatf("v%0d.unf", i), 32'(o_unf), 32'(v[i].unf));
      chk($sformatf("v%0d.mis", i), 32'(o_mis), 32'(v[i].mis));
    end
    repeat (2) @(posedge clk);

    // back-to-back A,B,C with a three-cycle output stall
    begin
      int sent = 0, got = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
        @(negedge clk);
        i_vld = (sent < 3); i_frac = 19'h40000; i_shamt = 5'd1;
        i_exp = seq_e[(sent < 3) ? sent : 2];
        o_rdy = (cyc >= 5);
        #1;
        if (cyc >= 2 && cyc <= 4) begin
          chk($sformatf("stall%0d.i_rdy", cyc), 32'(i_rdy), 32'd0);
          chk($sformatf("stall%0d.o_vld", cyc), 32'(o_vld), 32'd1);
          chk($sformatf("stall%0d.hold", cyc), 32'(o_exp), 32'd10);
        end
        if (o_vld && o_rdy) begin
          if (got < 3) chk($sformatf("order%0d", got), 32'(o_exp), 32'(seq_e[got]));
          got++;
        end
        if (i_vld && i_rdy) sent++;
      end
      i_vld = 1'b0;
      chk("seq.sent", 32'(sent), 32'd3);
      chk("seq.got", 32'(got), 32'd3);
    end

    // flush with two beats in flight
    @(negedge clk); o_rdy = 1'b0;
    i_vld = 1'b1; i_frac = 19'h40000; i_shamt = 5'd1; i_exp = 8'd40;
    @(posedge clk);
    @(negedge clk); i_exp = 8'd41;
    @(posedge clk);
    @(negedge clk);
    chk("fl.full", 32'(o_vld), 32'd1);
    i_flush = 1'b1; i_exp = 8'd42; #1;
    chk("fl.i_rdy", 32'(i_rdy), 32'd0);
    @(posedge clk); #1;
    chk("fl.o_vld", 32'(o_vld), 32'd0);
    @(negedge clk); i_flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("fl.empty%0d", c), 32'(o_vld), 32'd0);
    end

    // asynchronous reset while a beat is being presented
    @(negedge clk); o_rdy = 1'b0;
    i_vld = 1'b1; i_frac = 19'h00400; i_shamt = 5'd9; i_exp = 8'd100;
    @(posedge clk);
    @(negedge clk); i_vld = 1'b0;
    @(posedge clk); #1;
    chk("ar.o_vld_pre", 32'(o_vld), 32'd1);
    chk("ar.o_frac_pre", 32'(o_frac), 32'h40000);
    #1 rst = 1'b1;
    #1;
    chk("ar.o_vld", 32'(o_vld), 32'd0);
    chk("ar.o_frac", 32'(o_frac), 32'd0);
    chk("ar.o_exp", 32'(o_exp), 32'd0);
    @(negedge clk); rst = 1'b0; o_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ar.empty%0d", c), 32'(o_vld), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
